// File: rtl/tdes_pkg.sv
// Shared types and constants for the TDES pass sequencer.
package tdes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef logic [1:0]  stage_t;
    typedef logic [63:0] block_t;

    localparam logic   ENCRYPT    = 1'b1;
    localparam logic   DECRYPT    = 1'b0;
    localparam stage_t LAST_STAGE = 2'd2;

endpackage

// File: rtl/tdes_pass_sequencer_if.sv
// Handshake between the pass sequencer (master) and the shared single-DES core (slave).
interface tdes_pass_sequencer_if;
    import tdes_pkg::*;

    logic   core_start;
    logic   core_decrypt;
    block_t core_key;
    block_t core_din;
    logic   core_done;
    block_t core_dout;

    modport master (
        output core_start,
        output core_decrypt,
        output core_key,
        output core_din,
        input  core_done,
        input  core_dout
    );

    modport slave (
        input  core_start,
        input  core_decrypt,
        input  core_key,
        input  core_din,
        output core_done,
        output core_dout
    );

endinterface

// File: rtl/tdes_pass_select.sv
// Key and direction for one TDES pass, as a function of the pass index and operation type.
// Encrypt runs E(k1) D(k2) E(k3); decrypt runs D(k3) E(k2) D(k1). Stage 3 yields zeros.
module tdes_pass_select
    import tdes_pkg::*;
(
    input  stage_t stage,
    input  logic   enc_type,
    input  block_t key1,
    input  block_t key2,
    input  block_t key3,
    output block_t pass_key,
    output logic   pass_decrypt
);

    // Pass schedule lookup; the middle pass always runs opposite to the outer two.
    always_comb begin
        pass_key     = '0;
        pass_decrypt = 1'b0;
        case (stage)
            2'd0: begin
                pass_key     = (enc_type == ENCRYPT) ? key1 : key3;
                pass_decrypt = (enc_type == DECRYPT);
            end
            2'd1: begin
                pass_key     = key2;
                pass_decrypt = (enc_type == ENCRYPT);
            end
            2'd2: begin
                pass_key     = (enc_type == ENCRYPT) ? key3 : key1;
                pass_decrypt = (enc_type == DECRYPT);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tdes_pass_sequencer.sv
// Runs one Triple DES operation as three passes through a shared single-DES core.
// Optional build macro: TDES_TIMEOUT_EN adds a per-pass core_done timeout and the error flag.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for enable; last result held on outputData
// START  | core_start pulsed; pass key/direction/input already loaded
// WAIT   | waiting for core_done of the current pass
// FINISH | outputEnable just raised; returns to IDLE next cycle
module tdes_pass_sequencer
    import tdes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic                         enable,
    input  logic                         encryptionType,
    input  block_t                       data,
    input  block_t                       key1,
    input  block_t                       key2,
    input  block_t                       key3,
    tdes_pass_sequencer_if.master        core,
    output block_t                       outputData,
    output logic                         outputEnable,
    output logic                         busy,
    output logic                         error
);

    state_t state_q, state_n;
    stage_t stage_q, stage_n;
    logic   enc_q, enc_n;
    block_t key1_q, key1_n, key2_q, key2_n, key3_q, key3_n;
    block_t ckey_q, ckey_n, cdin_q, cdin_n;
    logic   cdec_q, cdec_n;
    block_t odata_q, odata_n;
    logic   oe_q, oe_n;
    logic   busy_q, busy_n;

    // Pass selector sees the raw operands while accepting (pass 0), else the latched set and next pass.
    stage_t sel_stage;
    logic   sel_enc;
    block_t sel_k1, sel_k2, sel_k3;
    block_t sel_key;
    logic   sel_dec;

    assign sel_stage = (state_q == IDLE) ? 2'd0 : stage_q + 2'd1;
    assign sel_enc   = (state_q == IDLE) ? encryptionType : enc_q;
    assign sel_k1    = (state_q == IDLE) ? key1 : key1_q;
    assign sel_k2    = (state_q == IDLE) ? key2 : key2_q;
    assign sel_k3    = (state_q == IDLE) ? key3 : key3_q;

    tdes_pass_select u_pass_select (
        .stage        (sel_stage),
        .enc_type     (sel_enc),
        .key1         (sel_k1),
        .key2         (sel_k2),
        .key3         (sel_k3),
        .pass_key     (sel_key),
        .pass_decrypt (sel_dec)
    );

`ifdef TDES_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter reads k-2 in the k-th cycle after core_start, so this fires in time for
    // error to be visible exactly TIMEOUT_CYCLES cycles after the start pulse.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);
    logic [TMO_W-1:0] tmo_q, tmo_n;
    logic             err_q, err_n;
    assign error = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign error      = 1'b0;
`endif

    // Next-state, operand latching and pass loading.
    always_comb begin
        state_n = state_q;
        stage_n = stage_q;
        enc_n   = enc_q;
        key1_n  = key1_q;
        key2_n  = key2_q;
        key3_n  = key3_q;
        ckey_n  = ckey_q;
        cdec_n  = cdec_q;
        cdin_n  = cdin_q;
        odata_n = odata_q;
        oe_n    = oe_q;
        busy_n  = busy_q;
`ifdef TDES_TIMEOUT_EN
        tmo_n   = tmo_q;
        err_n   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    enc_n   = encryptionType;
                    key1_n  = key1;
                    key2_n  = key2;
                    key3_n  = key3;
                    ckey_n  = sel_key;
                    cdec_n  = sel_dec;
                    cdin_n  = data;
                    stage_n = 2'd0;
                    oe_n    = 1'b0;
                    busy_n  = 1'b1;
`ifdef TDES_TIMEOUT_EN
                    err_n   = 1'b0;
`endif
                    state_n = START;
                end
            end
            START: begin
`ifdef TDES_TIMEOUT_EN
                tmo_n = '0;
`endif
                if (stage_q > LAST_STAGE) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (stage_q > LAST_STAGE) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (core.core_done) begin
                    if (stage_q == LAST_STAGE) begin
                        odata_n = core.core_dout;
                        oe_n    = 1'b1;
                        busy_n  = 1'b0;
                        state_n = FINISH;
                    end else begin
                        cdin_n  = core.core_dout;
                        ckey_n  = sel_key;
                        cdec_n  = sel_dec;
                        stage_n = stage_q + 2'd1;
                        state_n = START;
                    end
                end
`ifdef TDES_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    busy_n  = 1'b0;
                    oe_n    = 1'b0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo_q + 1'b1;
                end
`endif
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q <= IDLE;
            stage_q <= '0;
            enc_q   <= 1'b0;
            key1_q  <= '0;
            key2_q  <= '0;
            key3_q  <= '0;
            ckey_q  <= '0;
            cdec_q  <= 1'b0;
            cdin_q  <= '0;
            odata_q <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef TDES_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            stage_q <= stage_n;
            enc_q   <= enc_n;
            key1_q  <= key1_n;
            key2_q  <= key2_n;
            key3_q  <= key3_n;
            ckey_q  <= ckey_n;
            cdec_q  <= cdec_n;
            cdin_q  <= cdin_n;
            odata_q <= odata_n;
            oe_q    <= oe_n;
            busy_q  <= busy_n;
`ifdef TDES_TIMEOUT_EN
            tmo_q   <= tmo_n;
            err_q   <= err_n;
`endif
        end
    end

    assign core.core_start   = (state_q == START);
    assign core.core_decrypt = cdec_q;
    assign core.core_key     = ckey_q;
    assign core.core_din     = cdin_q;
    assign outputData        = odata_q;
    assign outputEnable      = oe_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// Directed bench for tdes_pass_sequencer with a fixed-latency reference core model.
// The core returns real DES results for the known key/plaintext pair and an invertible
// toy cipher for every other operand, so schedule and chaining errors change the result.
module tb_tdes_pass_sequencer;
    import tdes_pkg::*;

    localparam int     L      = 16;
    localparam int     TMO    = 64;
    localparam block_t K_DES  = 64'h133457799BBCDFF1;
    localparam block_t P_DES  = 64'h0123456789ABCDEF;
    localparam block_t C_DES  = 64'h85E813540F0AB405;
    localparam block_t K1     = 64'h1111111111111111;
    localparam block_t K2     = 64'h2222222222222222;
    localparam block_t K3     = 64'h3333333333333333;
    localparam block_t X_DATA = 64'h0F1E2D3C4B5A6978;

    logic   HCLK = 1'b0;
    logic   HRESET = 1'b0;
    logic   enable = 1'b0;
    logic   encryptionType = 1'b0;
    block_t data = '0, key1 = '0, key2 = '0, key3 = '0;
    block_t outputData;
    logic   outputEnable, busy, error;
    logic   core_mute = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    tdes_pass_sequencer_if core_if ();

    tdes_pass_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .enable         (enable),
        .encryptionType (encryptionType),
        .data           (data),
        .key1           (key1),
        .key2           (key2),
        .key3           (key3),
        .core           (core_if),
        .outputData     (outputData),
        .outputEnable   (outputEnable),
        .busy           (busy),
        .error          (error)
    );

    always #5 HCLK = ~HCLK;

    function automatic block_t core_fn(input logic dec, input block_t k, input block_t d);
        block_t t;
        if (k == K_DES && !dec && d == P_DES) return C_DES;
        if (k == K_DES && dec && d == C_DES) return P_DES;
        if (dec) begin
            t = {d[7:0], d[63:8]};
            return t ^ k;
        end
        t = d ^ k;
        return {t[55:0], t[63:56]};
    endfunction

    // Reference core: done pulses L cycles after start with the result computed at start.
    int     core_cnt = 0;
    int     n_starts = 0;
    block_t core_res = '0;
    block_t key_log [64];
    logic   dec_log [64];

    always @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            core_cnt <= 0;
        end else if (core_if.core_start) begin
            core_cnt               <= L;
            core_res               <= core_fn(core_if.core_decrypt, core_if.core_key, core_if.core_din);
            key_log[n_starts[5:0]] <= core_if.core_key;
            dec_log[n_starts[5:0]] <= core_if.core_decrypt;
            n_starts               <= n_starts + 1;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
        end
    end

    assign core_if.core_done = (core_cnt == 1) && !core_mute;
    assign core_if.core_dout = core_res;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse enable for cycle 0, scramble inputs afterwards, return at the negedge of cycle 1.
    task automatic start_op(input logic enc, input block_t d, input block_t k1,
                            input block_t k2, input block_t k3);
        @(negedge HCLK);
        enable = 1'b1;
        encryptionType = enc;
        data = d;
        key1 = k1;
        key2 = k2;
        key3 = k3;
        @(posedge HCLK);
        #1;
        enable = 1'b0;
        encryptionType = ~enc;
        data = ~d;
        key1 = ~k1;
        key2 = ~k2;
        key3 = ~k3;
        @(negedge HCLK);
    endtask

    // Starting at cycle 1, returns the cycle in which outputEnable is first seen high.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!outputEnable && cyc < 500) begin
            @(negedge HCLK);
            cyc++;
        end
        check_eq("oe_seen", 64'(outputEnable), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int     cyc;
        int     base;
        int     g;
        int     idx;
        block_t e_x;
        block_t exp_k [3];
        logic   exp_d [3];

        #12;
        check_eq("rst_data",  outputData, 64'h0);
        check_eq("rst_oe",    64'(outputEnable), 64'd0);
        check_eq("rst_busy",  64'(busy), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        check_eq("rst_start", 64'(core_if.core_start), 64'd0);
        check_eq("rst_key",   core_if.core_key, 64'h0);
        check_eq("rst_din",   core_if.core_din, 64'h0);
        @(negedge HCLK);
        HRESET = 1'b1;

        // DES-equivalent encrypt (all keys equal)
        base = n_starts;
        start_op(1'b1, P_DES, K_DES, K_DES, K_DES);
        check_eq("enc_c1_start", 64'(core_if.core_start), 64'd1);
        check_eq("enc_c1_busy",  64'(busy), 64'd1);
        check_eq("enc_c1_din",   core_if.core_din, P_DES);
        wait_done(cyc);
        check_eq("enc_data",   outputData, C_DES);
        check_eq("enc_cycle",  64'(cyc), 64'd52);
        check_eq("enc_busy",   64'(busy), 64'd0);
        check_eq("enc_starts", 64'(n_starts - base), 64'd3);
        repeat (4) @(negedge HCLK);
        check_eq("enc_oe_hold",   64'(outputEnable), 64'd1);
        check_eq("enc_data_hold", outputData, C_DES);

        // DES-equivalent decrypt
        start_op(1'b0, C_DES, K_DES, K_DES, K_DES);
        check_eq("dec_oe_clr", 64'(outputEnable), 64'd0);
        wait_done(cyc);
        check_eq("dec_data",  outputData, P_DES);
        check_eq("dec_cycle", 64'(cyc), 64'd52);

        // Pass schedule, encrypt
        e_x = core_fn(1'b0, K3, core_fn(1'b1, K2, core_fn(1'b0, K1, X_DATA)));
        base = n_starts;
        start_op(1'b1, X_DATA, K1, K2, K3);
        wait_done(cyc);
        exp_k = '{K1, K2, K3};
        exp_d = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            idx = base + i;
            check_eq($sformatf("sched_enc_key%0d", i), key_log[idx[5:0]], exp_k[i]);
            check_eq($sformatf("sched_enc_dec%0d", i), 64'(dec_log[idx[5:0]]), 64'(exp_d[i]));
        end
        check_eq("sched_enc_data", outputData, e_x);

        // Pass schedule, decrypt: must recover the original block
        base = n_starts;
        start_op(1'b0, e_x, K1, K2, K3);
        wait_done(cyc);
        exp_k = '{K3, K2, K1};
        exp_d = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            idx = base + i;
            check_eq($sformatf("sched_dec_key%0d", i), key_log[idx[5:0]], exp_k[i]);
            check_eq($sformatf("sched_dec_dec%0d", i), 64'(dec_log[idx[5:0]]), 64'(exp_d[i]));
        end
        check_eq("sched_dec_data", outputData, X_DATA);

        // enable during pass 1 is ignored
        base = n_starts;
        start_op(1'b1, X_DATA, K1, K2, K3);
        g = 0;
        while (n_starts < base + 2 && g < 200) begin
            @(negedge HCLK);
            g++;
        end
        check_eq("busy_reached_p1", 64'(n_starts - base), 64'd2);
        enable = 1'b1;
        encryptionType = 1'b0;
        data = 64'hDEADBEEFCAFEF00D;
        key1 = 64'h4444444444444444;
        @(negedge HCLK);
        enable = 1'b0;
        g = 0;
        while (!outputEnable && g < 500) begin
            @(negedge HCLK);
            g++;
        end
        check_eq("busy_oe",     64'(outputEnable), 64'd1);
        check_eq("busy_data",   outputData, e_x);
        repeat (L + 4) @(negedge HCLK);
        check_eq("busy_starts", 64'(n_starts - base), 64'd3);

        // Reset during the third pass of a decrypt
        base = n_starts;
        start_op(1'b0, e_x, K1, K2, K3);
        g = 0;
        while (n_starts < base + 3 && g < 200) begin
            @(negedge HCLK);
            g++;
        end
        repeat (4) @(negedge HCLK);
        check_eq("rstmid_busy_before", 64'(busy), 64'd1);
        check_eq("rstmid_key_before",  core_if.core_key, K1);
        HRESET = 1'b0;
        #1;
        check_eq("rstmid_busy", 64'(busy), 64'd0);
        check_eq("rstmid_data", outputData, 64'h0);
        check_eq("rstmid_oe",   64'(outputEnable), 64'd0);
        check_eq("rstmid_key",  core_if.core_key, 64'h0);
        check_eq("rstmid_din",  core_if.core_din, 64'h0);
        check_eq("rstmid_dec",  64'(core_if.core_decrypt), 64'd0);
        @(negedge HCLK);
        HRESET = 1'b1;
        repeat (20) @(negedge HCLK);
        check_eq("rstmid_idle_oe", 64'(outputEnable), 64'd0);
        start_op(1'b1, X_DATA, K1, K2, K3);
        wait_done(cyc);
        check_eq("rstmid_after_data",  outputData, e_x);
        check_eq("rstmid_after_cycle", 64'(cyc), 64'd52);

`ifdef TDES_TIMEOUT_EN
        // Core never answers: error and idle exactly TMO cycles after core_start
        core_mute = 1'b1;
        start_op(1'b1, X_DATA, K1, K2, K3);
        cyc = 1;
        while (!error && cyc < 300) begin
            @(negedge HCLK);
            cyc++;
        end
        check_eq("tmo_cycle", 64'(cyc), 64'(1 + TMO));
        check_eq("tmo_busy",  64'(busy), 64'd0);
        check_eq("tmo_oe",    64'(outputEnable), 64'd0);
        repeat (5) @(negedge HCLK);
        check_eq("tmo_sticky", 64'(error), 64'd1);
        core_mute = 1'b0;
        start_op(1'b0, e_x, K1, K2, K3);
        check_eq("tmo_err_clr", 64'(error), 64'd0);
        wait_done(cyc);
        check_eq("tmo_after_data", outputData, X_DATA);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
